vga_sync_monitor: RTL

- Receive-side counterpart of the VGA timing generator. Watches the hsync/vsync pair the generator drives to the connector and recovers pixel coordinates and an active-video flag.
- Checks every line and frame against the 640x480@60 timing parameters and reports a lock state.
- Sits beside vga_display in the AirHockey top, on clk25. Used for self-check and on-chip debug. Output goes to the seven-segment path or a probe.

---
 rtl/vga_sync_monitor_if.sv | 30 +++
 rtl/vga_sync_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_monitor_if                                                        |
// | Sync inputs and recovered-timing outputs of the VGA sync monitor.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vga_sync_monitor_if;
  logic       hsync;
  logic       vsync;
  logic [9:0] xpos_rec;
  logic [9:0] ypos_rec;
  logic       active;
  logic       locked;
  logic       h_err;
  logic       v_err;
  logic [7:0] frame_count;

  // Sync source / probe side
  modport master (
    output hsync, vsync,
    input  xpos_rec, ypos_rec, active, locked, h_err, v_err, frame_count
  );

  // Monitor side
  modport slave (
    input  hsync, vsync,
    output xpos_rec, ypos_rec, active, locked, h_err, v_err, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_monitor                                                           |
// | Recovers pixel coordinates from hsync/vsync, checks timing, reports lock.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_sync_monitor #(
  parameter int H_ACT       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACT       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk25,
  input  logic              rst,
  vga_sync_monitor_if.slave mon
);

  localparam logic [11:0] c_H_TOT   = 12'(H_ACT + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] c_H_SYNC  = 11'(H_SYNC);
  localparam logic [10:0] c_H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] c_H_END   = 11'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0]  c_X0      = 10'(H_SYNC + H_BP);
  localparam logic [10:0] c_V_TOT   = 11'(V_ACT + V_FP + V_SYNC + V_BP);
  localparam logic [9:0]  c_V_SYNC  = 10'(V_SYNC);
  localparam logic [9:0]  c_V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  c_V_END   = 10'(V_SYNC + V_BP + V_ACT);
  localparam int          c_GOOD_W  = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [c_GOOD_W-1:0] c_LOCK_N = c_GOOD_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_GOOD_W-1:0] good_q, good_d;
  logic                locked_q, locked_d;
  logic [7:0]          fcnt_q, fcnt_d;
  logic                h_err_q, v_err_q;

  logic                hs_q, vs_q;
  logic [10:0]         hcnt_q, hcnt_d;
  logic [10:0]         hlow_q, hlow_d;
  logic [9:0]          vcnt_q, vcnt_d;
  logic [9:0]          vlow_q, vlow_d;
  logic                h_seen_q, v_seen_q;

  logic                w_hf, w_hr, w_vf, w_vr;
  logic [11:0]         w_line_len;
  logic [10:0]         w_frame_len;
  logic [10:0]         w_hlow_inc;
  logic [9:0]          w_vlow_inc;
  logic                w_h_err, w_v_err, w_err;
  logic                w_active;

  assign w_hf = hs_q & ~mon.hsync;
  assign w_hr = ~hs_q & mon.hsync;
  assign w_vf = vs_q & ~mon.vsync;
  assign w_vr = ~vs_q & mon.vsync;

  // Width counters include the current cycle, so the count is complete on the rising edge
  assign w_hlow_inc = (!hs_q && !(&hlow_q)) ? hlow_q + 11'd1 : hlow_q;
  assign w_vlow_inc = (w_hf && !vs_q && !(&vlow_q)) ? vlow_q + 10'd1 : vlow_q;

  assign w_line_len  = {1'b0, hcnt_q} + 12'd1;
  assign w_frame_len = {1'b0, vcnt_q} + 11'd1;

  // Checks stay disarmed until one full period has been seen since reset
  assign w_h_err = (w_hf && h_seen_q && (w_line_len != c_H_TOT)) ||
                   (w_hr && h_seen_q && (w_hlow_inc != c_H_SYNC));
  assign w_v_err = (w_vf && v_seen_q && (w_frame_len != c_V_TOT)) ||
                   (w_vr && v_seen_q && (w_vlow_inc != c_V_SYNC));
  assign w_err   = w_h_err | w_v_err;

  always_comb begin
    hcnt_d = hcnt_q;
    if (w_hf) begin
      hcnt_d = '0;
    end else if (!(&hcnt_q)) begin
      hcnt_d = hcnt_q + 11'd1;
    end

    hlow_d = w_hf ? '0 : w_hlow_inc;

    vcnt_d = vcnt_q;
    if (w_vf) begin
      vcnt_d = '0;
    end else if (w_hf && !(&vcnt_q)) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    vlow_d = w_vf ? '0 : w_vlow_inc;
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      hcnt_q   <= '0;
      hlow_q   <= '0;
      vcnt_q   <= '0;
      vlow_q   <= '0;
      h_seen_q <= 1'b0;
      v_seen_q <= 1'b0;
      h_err_q  <= 1'b0;
      v_err_q  <= 1'b0;
    end else begin
      hs_q     <= mon.hsync;
      vs_q     <= mon.vsync;
      hcnt_q   <= hcnt_d;
      hlow_q   <= hlow_d;
      vcnt_q   <= vcnt_d;
      vlow_q   <= vlow_d;
      h_seen_q <= h_seen_q | w_hf;
      v_seen_q <= v_seen_q | w_vf;
      h_err_q  <= w_h_err;
      v_err_q  <= w_v_err;
    end
  end

  // An error in the same cycle as a VF wins: the frame is neither counted nor locked on
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (w_vf && !w_err) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (w_err) begin
          state_d = ST_SEARCH;
          good_d  = '0;
        end else if (w_vf) begin
          if (good_q + 1'b1 == c_LOCK_N) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (w_err) begin
          state_d = ST_SEARCH;
        end else if (w_vf) begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = '0;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign w_active = locked_q &&
                    (hcnt_q >= c_H_START) && (hcnt_q < c_H_END) &&
                    (vcnt_q >= c_V_START) && (vcnt_q < c_V_END);

  assign mon.active      = w_active;
  assign mon.xpos_rec    = w_active ? (hcnt_q[9:0] - c_X0) : '0;
  assign mon.ypos_rec    = w_active ? (vcnt_q - c_V_START) : '0;
  assign mon.locked      = locked_q;
  assign mon.h_err       = h_err_q;
  assign mon.v_err       = v_err_q;
  assign mon.frame_count = fcnt_q;

endmodule
`default_nettype wire
